ram_responder: RTL and testbench



---
 rtl/ram_responder_pkg.sv | 23 ++
 rtl/ram_responder_if.sv | 24 ++
 rtl/ram_lat_counter.sv | 86 ++++++++
 rtl/ram_responder.sv | 79 +++++++
 tb/tb_ram_responder.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/ram_responder_pkg.sv
// rtl/ram_responder_pkg.sv - shared types for the ram bus responder
// Contents: word_t, ramstate_t (FREE/BUSY/ACCESS/ERROR), latency reload helper.
package ram_responder_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Countdown reload for a new transaction; the first BUSY cycle is the
  // request cycle itself, so the counter starts one below the latency.
  function automatic logic [3:0] lat_reload(input int lat);
    if (lat <= 0) return 4'd0;
    return 4'(lat - 1);
  endfunction

endpackage

// File: rtl/ram_responder_if.sv
// rtl/ram_responder_if.sv - ram bus between arbiter (master) and RAM (slave)
// Signals: ramREN/ramWEN request, ramaddr byte address, ramstore write data,
//          ramload read data, ramstate handshake.
interface ram_responder_if;
  import ram_responder_pkg::*;

  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport master (
    output ramREN, ramWEN, ramaddr, ramstore,
    input  ramload, ramstate
  );

  modport slave (
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramstate
  );

endinterface

// File: rtl/ram_lat_counter.sv
// rtl/ram_lat_counter.sv - in-flight tracking and latency countdown
// Ports: clk, rst (sync, active-high), valid (legal request present),
//        addr/wen/store (current request fields), busy/access strobes.
module ram_lat_counter
  import ram_responder_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  valid,
  input  word_t addr,
  input  logic  wen,
  input  word_t store,
  output logic  busy,
  output logic  access
);

  localparam logic [3:0] LAT_M1 = lat_reload(LAT);

  logic        pend,   pend_n;
  logic [3:0]  cnt,    cnt_n;
  word_t       paddr,  paddr_n;
  logic        pwen,   pwen_n;
  word_t       pstore, pstore_n;
  logic        is_new;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend   <= 1'b0;
      cnt    <= 4'd0;
      paddr  <= '0;
      pwen   <= 1'b0;
      pstore <= '0;
    end else begin
      pend   <= pend_n;
      cnt    <= cnt_n;
      paddr  <= paddr_n;
      pwen   <= pwen_n;
      pstore <= pstore_n;
    end
  end

  // The arbiter can retarget combinationally, so any change in the request
  // fields while pending restarts the countdown. Store data only matters
  // for writes.
  assign is_new = valid &&
                  (!pend || (addr != paddr) || (wen != pwen) ||
                   (wen && (store != pstore)));

  always_comb begin
    pend_n   = pend;
    cnt_n    = cnt;
    paddr_n  = paddr;
    pwen_n   = pwen;
    pstore_n = pstore;
    busy     = 1'b0;
    access   = 1'b0;
    if (!rst) begin
      if (!valid) begin
        pend_n = 1'b0;
      end else if (is_new) begin
        if (LAT == 0) begin
          access = 1'b1;
          pend_n = 1'b0;
        end else begin
          busy     = 1'b1;
          pend_n   = 1'b1;
          cnt_n    = LAT_M1;
          paddr_n  = addr;
          pwen_n   = wen;
          pstore_n = store;
        end
      end else if (cnt != 4'd0) begin
        busy  = 1'b1;
        cnt_n = cnt - 4'd1;
      end else begin
        // Clearing pend makes a held request count as new next cycle, so
        // ACCESS cycles never run back-to-back when LAT > 0.
        access = 1'b1;
        pend_n = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - word-addressed RAM model with programmable latency
// Ports: CLK, RST (sync, active-high), ram (slave side of ram_responder_if).
// Parameters: LAT wait cycles before ACCESS (0..15), DEPTH 32-bit words.
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int LAT   = 2,
  parameter int DEPTH = 1024
) (
  input  logic          CLK,
  input  logic          RST,
  ram_responder_if.slave ram
);

  localparam int    AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam word_t ADDR_MAX = word_t'(4 * DEPTH);

  word_t          mem [DEPTH];
  logic           req;
  logic           err;
  logic           valid;
  logic           busy;
  logic           access;
  logic [AW-1:0]  widx;
  ramstate_t      state;
  word_t          load;

  assign req   = ram.ramREN | ram.ramWEN;
  assign err   = (ram.ramREN & ram.ramWEN) |
                 (ram.ramaddr[1:0] != 2'b00) |
                 (ram.ramaddr >= ADDR_MAX);
  assign valid = req & ~err;
  // Only meaningful for in-range addresses, which valid guarantees.
  assign widx  = ram.ramaddr[AW+1:2];

  ram_lat_counter #(
    .LAT (LAT)
  ) u_lat (
    .clk    (CLK),
    .rst    (RST),
    .valid  (valid),
    .addr   (ram.ramaddr),
    .wen    (ram.ramWEN),
    .store  (ram.ramstore),
    .busy   (busy),
    .access (access)
  );

  always_comb begin
    state = FREE;
    load  = '0;
    if (!RST) begin
      if (err) begin
        state = ERROR;
      end else if (!req) begin
        state = FREE;
      end else if (access) begin
        state = ACCESS;
        if (ram.ramREN) load = mem[widx];
      end else if (busy) begin
        state = BUSY;
      end
    end
  end

  // Writes commit at the edge closing the ACCESS cycle, so a following
  // read of the same word sees the new data.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (access && ram.ramWEN) begin
      mem[widx] <= ram.ramstore;
    end
  end

  assign ram.ramstate = state;
  assign ram.ramload  = load;

endmodule

// File: tb/tb_ram_responder.sv
// tb/tb_ram_responder.sv - directed bench for ram_responder at LAT 2, 3 and 0
module tb_ram_responder;
  import ram_responder_pkg::*;

  logic CLK;
  logic RST;
  int   checks;
  int   failures;

  ram_responder_if if2 ();
  ram_responder_if if3 ();
  ram_responder_if if0 ();

  ram_responder #(.LAT(2), .DEPTH(1024)) u_lat2 (.CLK(CLK), .RST(RST), .ram(if2));
  ram_responder #(.LAT(3), .DEPTH(1024)) u_lat3 (.CLK(CLK), .RST(RST), .ram(if3));
  ram_responder #(.LAT(0), .DEPTH(1024)) u_lat0 (.CLK(CLK), .RST(RST), .ram(if0));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Each cyc task occupies one clock: drive at the falling edge, sample the
  // combinational outputs 1 time unit later, well before the rising edge.
  task automatic cyc2(input logic ren, input logic wen, input word_t addr, input word_t store,
                      input ramstate_t es, input word_t el, input string tag);
    @(negedge CLK);
    if2.ramREN = ren; if2.ramWEN = wen; if2.ramaddr = addr; if2.ramstore = store;
    #1;
    check({tag, ".state"}, {30'd0, if2.ramstate}, {30'd0, es});
    check({tag, ".load"}, if2.ramload, el);
  endtask

  task automatic cyc3(input logic ren, input logic wen, input word_t addr, input word_t store,
                      input ramstate_t es, input word_t el, input string tag);
    @(negedge CLK);
    if3.ramREN = ren; if3.ramWEN = wen; if3.ramaddr = addr; if3.ramstore = store;
    #1;
    check({tag, ".state"}, {30'd0, if3.ramstate}, {30'd0, es});
    check({tag, ".load"}, if3.ramload, el);
  endtask

  task automatic cyc0(input logic ren, input logic wen, input word_t addr, input word_t store,
                      input ramstate_t es, input word_t el, input string tag);
    @(negedge CLK);
    if0.ramREN = ren; if0.ramWEN = wen; if0.ramaddr = addr; if0.ramstore = store;
    #1;
    check({tag, ".state"}, {30'd0, if0.ramstate}, {30'd0, es});
    check({tag, ".load"}, if0.ramload, el);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RST = 1'b1;
    if2.ramREN = 1'b0; if2.ramWEN = 1'b0; if2.ramaddr = '0; if2.ramstore = '0;
    if3.ramREN = 1'b0; if3.ramWEN = 1'b0; if3.ramaddr = '0; if3.ramstore = '0;
    if0.ramREN = 1'b0; if0.ramWEN = 1'b0; if0.ramaddr = '0; if0.ramstore = '0;

    // Reset held for two cycles
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      #1;
      check("rst.lat2.state", {30'd0, if2.ramstate}, {30'd0, FREE});
      check("rst.lat2.load",  if2.ramload, 32'h0);
      check("rst.lat0.state", {30'd0, if0.ramstate}, {30'd0, FREE});
    end
    @(negedge CLK);
    RST = 1'b0;

    // Idle
    for (int i = 0; i < 3; i++) cyc2(1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0, "idle");

    // LAT=2 write then read
    cyc2(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, BUSY,   32'h0, "wr10.c0");
    cyc2(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, BUSY,   32'h0, "wr10.c1");
    cyc2(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, ACCESS, 32'h0, "wr10.c2");
    cyc2(1'b1, 1'b0, 32'h10, 32'h0, BUSY,   32'h0,        "rd10.c0");
    cyc2(1'b1, 1'b0, 32'h10, 32'h0, BUSY,   32'h0,        "rd10.c1");
    cyc2(1'b1, 1'b0, 32'h10, 32'h0, ACCESS, 32'hDEADBEEF, "rd10.c2");
    // Held past ACCESS: fresh countdown, no back-to-back ACCESS
    cyc2(1'b1, 1'b0, 32'h10, 32'h0, BUSY,   32'h0,        "rd10.held");
    // Dropped mid-countdown
    cyc2(1'b0, 1'b0, 32'h10, 32'h0, FREE,   32'h0,        "rd10.drop");

    // Error cases, none may touch memory
    cyc2(1'b1, 1'b1, 32'h0,    32'h77, ERROR, 32'h0, "err.both");
    cyc2(1'b1, 1'b0, 32'h2,    32'h0,  ERROR, 32'h0, "err.misrd");
    cyc2(1'b0, 1'b1, 32'h2,    32'h99, ERROR, 32'h0, "err.miswr");
    cyc2(1'b1, 1'b0, 32'h1000, 32'h0,  ERROR, 32'h0, "err.oorrd");
    cyc2(1'b0, 1'b1, 32'h1000, 32'h66, ERROR, 32'h0, "err.oorwr");
    cyc2(1'b1, 1'b0, 32'h0, 32'h0, BUSY,   32'h0, "rd0.c0");
    cyc2(1'b1, 1'b0, 32'h0, 32'h0, BUSY,   32'h0, "rd0.c1");
    cyc2(1'b1, 1'b0, 32'h0, 32'h0, ACCESS, 32'h0, "rd0.c2");

    // Last legal word
    cyc2(1'b0, 1'b1, 32'hFFC, 32'hCAFEF00D, BUSY,   32'h0, "wrffc.c0");
    cyc2(1'b0, 1'b1, 32'hFFC, 32'hCAFEF00D, BUSY,   32'h0, "wrffc.c1");
    cyc2(1'b0, 1'b1, 32'hFFC, 32'hCAFEF00D, ACCESS, 32'h0, "wrffc.c2");
    cyc2(1'b1, 1'b0, 32'hFFC, 32'h0, BUSY,   32'h0,        "rdffc.c0");
    cyc2(1'b1, 1'b0, 32'hFFC, 32'h0, BUSY,   32'h0,        "rdffc.c1");
    cyc2(1'b1, 1'b0, 32'hFFC, 32'h0, ACCESS, 32'hCAFEF00D, "rdffc.c2");
    cyc2(1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0, "idle2");

    // LAT=3: preload 0x24, then retarget a read from 0x20 to 0x24
    cyc3(1'b0, 1'b1, 32'h24, 32'hA5A50001, BUSY,   32'h0, "l3wr24.c0");
    cyc3(1'b0, 1'b1, 32'h24, 32'hA5A50001, BUSY,   32'h0, "l3wr24.c1");
    cyc3(1'b0, 1'b1, 32'h24, 32'hA5A50001, BUSY,   32'h0, "l3wr24.c2");
    cyc3(1'b0, 1'b1, 32'h24, 32'hA5A50001, ACCESS, 32'h0, "l3wr24.c3");
    cyc3(1'b1, 1'b0, 32'h20, 32'h0, BUSY,   32'h0,        "l3rd20.c0");
    cyc3(1'b1, 1'b0, 32'h20, 32'h0, BUSY,   32'h0,        "l3rd20.c1");
    cyc3(1'b1, 1'b0, 32'h24, 32'h0, BUSY,   32'h0,        "l3rd24.c0");
    cyc3(1'b1, 1'b0, 32'h24, 32'h0, BUSY,   32'h0,        "l3rd24.c1");
    cyc3(1'b1, 1'b0, 32'h24, 32'h0, BUSY,   32'h0,        "l3rd24.c2");
    cyc3(1'b1, 1'b0, 32'h24, 32'h0, ACCESS, 32'hA5A50001, "l3rd24.c3");
    cyc3(1'b0, 1'b0, 32'h0,  32'h0, FREE,   32'h0,        "l3idle");

    // LAT=0: same-cycle ACCESS, back-to-back and held
    cyc0(1'b0, 1'b1, 32'h4, 32'h1, ACCESS, 32'h0, "l0wr4");
    cyc0(1'b1, 1'b0, 32'h4, 32'h0, ACCESS, 32'h1, "l0rd4.c0");
    cyc0(1'b1, 1'b0, 32'h4, 32'h0, ACCESS, 32'h1, "l0rd4.c1");
    cyc0(1'b0, 1'b0, 32'h0, 32'h0, FREE,   32'h0, "l0idle");

    // Reset during the second BUSY cycle of a LAT=2 write
    cyc2(1'b0, 1'b1, 32'h8, 32'h55, BUSY, 32'h0, "rstwr8.c0");
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check("rstwr8.rst.state", {30'd0, if2.ramstate}, {30'd0, FREE});
    check("rstwr8.rst.load",  if2.ramload, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    if2.ramREN = 1'b0; if2.ramWEN = 1'b0; if2.ramaddr = '0; if2.ramstore = '0;
    #1;
    check("rstwr8.after.state", {30'd0, if2.ramstate}, {30'd0, FREE});
    cyc2(1'b1, 1'b0, 32'h8,  32'h0, BUSY,   32'h0, "rd8.c0");
    cyc2(1'b1, 1'b0, 32'h8,  32'h0, BUSY,   32'h0, "rd8.c1");
    cyc2(1'b1, 1'b0, 32'h8,  32'h0, ACCESS, 32'h0, "rd8.c2");
    // Reset also cleared the earlier 0xDEADBEEF
    cyc2(1'b1, 1'b0, 32'h10, 32'h0, BUSY,   32'h0, "rd10r.c0");
    cyc2(1'b1, 1'b0, 32'h10, 32'h0, BUSY,   32'h0, "rd10r.c1");
    cyc2(1'b1, 1'b0, 32'h10, 32'h0, ACCESS, 32'h0, "rd10r.c2");
    cyc2(1'b0, 1'b0, 32'h0,  32'h0, FREE,   32'h0, "final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
